// File: rtl/fetch_btb_if.sv
// fetch_btb_if -- bundle between the pipeline and the fetch/BTB block.
//
// Handshake: there is no valid/ready pair on this bundle. The EX fields are
// sampled every rising edge, and "en" is the only qualifier. en = 1 lets
// fetch advance and lets a resolved branch train the BTB. en = 0 stalls
// fetch, but a misprediction flush still redirects the PC.
//
// Signals
//   en                  fetch advance enable (low = stall)
//   EX_pc_i             PC of the instruction in EX
//   EX_bp_pred_taken_i  prediction made for the EX instruction at fetch
//   EX_bp_pred_pc_i     predicted next PC for the EX instruction
//   EX_is_br_i          EX instruction is a BTB-tracked branch
//   EX_br_taken_i       resolved branch outcome
//   EX_br_target_i      resolved branch target
//   EX_pc_p4_i          EX PC + 4
//   EX_csr_br_taken_i   trap / xRET redirect
//   EX_csr_br_target_i  trap / xRET target
//   br_flush_o          misprediction flush
//   bp_pred_taken_o     prediction for the current fetch PC
//   bp_pred_target_o    predicted target for the current fetch PC
//   pc_o, pc_p4_o       fetch PC and fetch PC + 4
//
// Modports: slave = fetch_btb, master = pipeline / testbench.
interface fetch_btb_if;
  logic        en;
  logic [31:0] EX_pc_i;
  logic        EX_bp_pred_taken_i;
  logic [31:0] EX_bp_pred_pc_i;
  logic        EX_is_br_i;
  logic        EX_br_taken_i;
  logic [31:0] EX_br_target_i;
  logic [31:0] EX_pc_p4_i;
  logic        EX_csr_br_taken_i;
  logic [31:0] EX_csr_br_target_i;
  logic        br_flush_o;
  logic        bp_pred_taken_o;
  logic [31:0] bp_pred_target_o;
  logic [31:0] pc_o;
  logic [31:0] pc_p4_o;

  modport slave (
    input  en, EX_pc_i, EX_bp_pred_taken_i, EX_bp_pred_pc_i, EX_is_br_i,
           EX_br_taken_i, EX_br_target_i, EX_pc_p4_i, EX_csr_br_taken_i,
           EX_csr_br_target_i,
    output br_flush_o, bp_pred_taken_o, bp_pred_target_o, pc_o, pc_p4_o
  );

  modport master (
    output en, EX_pc_i, EX_bp_pred_taken_i, EX_bp_pred_pc_i, EX_is_br_i,
           EX_br_taken_i, EX_br_target_i, EX_pc_p4_i, EX_csr_br_taken_i,
           EX_csr_br_target_i,
    input  br_flush_o, bp_pred_taken_o, bp_pred_target_o, pc_o, pc_p4_o
  );
endinterface

// File: rtl/fetch_btb.sv
// fetch_btb -- fetch PC register with a direct-mapped branch target buffer.
//
// The block holds the fetch PC and resolves the EX-stage next PC. It raises
// br_flush_o when the path fetched after the EX instruction was wrong. When
// prediction is built in, a BTB with 2-bit saturating counters supplies a
// taken prediction and a target for the current fetch PC.
//
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (PC <= RESET_PC, BTB valid cleared)
//   bus    fetch_btb_if.slave (EX resolution inputs, fetch outputs)
//
// Configuration macro: FETCH_BTB_PRED_EN
//   defined   : BTB lookup and training are built in
//   undefined : no BTB storage; fetch runs sequentially and is redirected
//               only by flushes
//
// The block has no FSM. Its only state is the PC register and the BTB
// arrays.
module fetch_btb #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16,
  parameter int          TAG_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_btb_if.slave  bus
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_p4;
  logic [31:0] ex_next_pc;
  logic        flush;
  logic        pred_taken;
  logic [31:0] pred_target;

  // The EX next PC follows a fixed priority: trap/xRET first, then the
  // resolved branch, then the fall-through path.
  always_comb begin
    ex_next_pc = bus.EX_pc_p4_i;
    if (bus.EX_csr_br_taken_i)  ex_next_pc = bus.EX_csr_br_target_i;
    else if (bus.EX_br_taken_i) ex_next_pc = bus.EX_br_target_i;
  end

  // The path fetched after EX was either the predicted PC or PC+4. A flush
  // is needed whenever the resolved next PC differs from that path.
  assign flush = bus.EX_bp_pred_taken_i ? (ex_next_pc != bus.EX_bp_pred_pc_i)
                                        : (ex_next_pc != bus.EX_pc_p4_i);

  assign pc_p4 = pc_q + 32'd4;

`ifdef FETCH_BTB_PRED_EN
  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
  logic [31:0]            tgt_q [BTB_ENTRIES];
  logic [1:0]             cnt_q [BTB_ENTRIES];

  logic [IDX_W-1:0] fe_idx;
  logic [TAG_W-1:0] fe_tag;
  logic             fe_hit;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             upd_en;
  logic             wr_en;
  logic             alloc_en;
  logic [1:0]       wr_cnt_d;
  logic [31:0]      wr_tgt_d;
  logic             unused_ex_bits;

  // Lookup for the current fetch PC. It reads the registered arrays, so a
  // write made in the same cycle is seen only from the next cycle.
  assign fe_idx      = pc_q[IDX_W+1:2];
  assign fe_tag      = pc_q[IDX_W+TAG_W+1:IDX_W+2];
  assign fe_hit      = valid_q[fe_idx] && (tag_q[fe_idx] == fe_tag);
  assign pred_taken  = fe_hit && cnt_q[fe_idx][1];
  assign pred_target = fe_hit ? tgt_q[fe_idx] : 32'd0;

  // Training from EX. Trap/xRET redirects never train the BTB.
  assign ex_idx   = bus.EX_pc_i[IDX_W+1:2];
  assign ex_tag   = bus.EX_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign upd_en   = bus.en && bus.EX_is_br_i && !bus.EX_csr_br_taken_i;
  // A not-taken miss writes nothing. A taken miss replaces whatever entry
  // sits at this index.
  assign alloc_en = upd_en && !ex_hit && bus.EX_br_taken_i;
  assign wr_en    = (upd_en && ex_hit) || alloc_en;

  always_comb begin
    wr_cnt_d = cnt_q[ex_idx];
    wr_tgt_d = tgt_q[ex_idx];
    if (!ex_hit) begin
      wr_cnt_d = 2'b10;
      wr_tgt_d = bus.EX_br_target_i;
    end else if (bus.EX_br_taken_i) begin
      if (cnt_q[ex_idx] != 2'b11) wr_cnt_d = cnt_q[ex_idx] + 2'b01;
      wr_tgt_d = bus.EX_br_target_i;
    end else begin
      if (cnt_q[ex_idx] != 2'b00) wr_cnt_d = cnt_q[ex_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (alloc_en) begin
      valid_q[ex_idx] <= 1'b1;
    end
  end

  // Tag, target and counter need no reset because valid guards them. The
  // rst_n term keeps reset ahead of any training write.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      tag_q[ex_idx] <= ex_tag;
      tgt_q[ex_idx] <= wr_tgt_d;
      cnt_q[ex_idx] <= wr_cnt_d;
    end
  end

  assign unused_ex_bits = ^{bus.EX_pc_i[31:IDX_W+TAG_W+2], bus.EX_pc_i[1:0]};
`else
  logic unused_ex_bits;

  assign pred_taken     = 1'b0;
  assign pred_target    = 32'd0;
  assign unused_ex_bits = ^{bus.EX_pc_i, bus.EX_is_br_i};
`endif

  always_comb begin
    pc_d = pc_p4;
    if (flush)           pc_d = ex_next_pc;
    else if (pred_taken) pc_d = pred_target;
  end

  // A flush redirects the PC even when fetch is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (bus.en || flush) begin
      pc_q <= pc_d;
    end
  end

  assign bus.pc_o             = pc_q;
  assign bus.pc_p4_o          = pc_p4;
  assign bus.br_flush_o       = flush;
  assign bus.bp_pred_taken_o  = pred_taken;
  assign bus.bp_pred_target_o = pred_target;

endmodule
